// File: rtl/md_sched_pkg.sv
// rtl/md_sched_pkg.sv - shared states and constants for the multdiv writeback scheduler
package md_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WB   = 2'd2
    } md_state_t;

    localparam logic [31:0] STATUS_MULT = 32'd4;
    localparam logic [31:0] STATUS_DIV  = 32'd5;
    localparam logic [4:0]  RSTATUS_REG = 5'd30;
    localparam logic [5:0]  TIMEOUT     = 6'd63;

    function automatic logic [31:0] status_code(input logic is_div);
        return is_div ? STATUS_DIV : STATUS_MULT;
    endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// rtl/md_timeout_counter.sv - saturating RUN-cycle counter with timeout flag
module md_timeout_counter
    import md_sched_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);

    logic [5:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= 6'd0;
        end else if (enable && (count != TIMEOUT)) begin
            count <= count + 6'd1;
        end
    end

    assign done = (count == TIMEOUT);

endmodule

// File: rtl/multdiv_sched.sv
// rtl/multdiv_sched.sv - launches mult/div ops, tracks timeout, arbitrates the regfile write port
module multdiv_sched
    import md_sched_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [4:0]  issue_rd,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    input  logic        wb_pipe_en,
    input  logic [4:0]  wb_pipe_reg,
    input  logic [31:0] wb_pipe_data,
    output logic        md_start_mult,
    output logic        md_start_div,
    output logic        stall,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic        busy
);

    md_state_t   state;
    logic [4:0]  rd_q;
    logic        is_div_q;
    logic [4:0]  buf_reg;
    logic [31:0] buf_data;
    logic        accept;
    logic        timed_out;
    logic        grant;

    // Gating with reset keeps a start pulse from escaping while the op would be discarded.
    assign accept = (state == ST_IDLE) && issue_valid && !reset;

    md_timeout_counter u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept),
        .enable (state == ST_RUN),
        .done   (timed_out)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            rd_q     <= 5'd0;
            is_div_q <= 1'b0;
            buf_reg  <= 5'd0;
            buf_data <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue_valid) begin
                        rd_q     <= issue_rd;
                        is_div_q <= issue_is_div;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (md_ready) begin
                        if (md_exception) begin
                            buf_reg  <= RSTATUS_REG;
                            buf_data <= status_code(is_div_q);
                            state    <= ST_WB;
                        end else if (rd_q == 5'd0) begin
                            state    <= ST_IDLE;
                        end else begin
                            buf_reg  <= rd_q;
                            buf_data <= md_result;
                            state    <= ST_WB;
                        end
                    end else if (timed_out) begin
                        buf_reg  <= RSTATUS_REG;
                        buf_data <= status_code(is_div_q);
                        state    <= ST_WB;
                    end
                end
                ST_WB: begin
                    if (!wb_pipe_en) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The pipeline always wins the port; the buffered write waits for a free cycle.
    assign grant            = (state == ST_WB) && !wb_pipe_en;
    assign ctrl_writeEnable = grant || wb_pipe_en;
    assign ctrl_writeReg    = grant ? buf_reg  : wb_pipe_reg;
    assign data_writeReg    = grant ? buf_data : wb_pipe_data;

    assign md_start_mult = accept && !issue_is_div;
    assign md_start_div  = accept && issue_is_div;
    assign busy          = (state != ST_IDLE);
    assign stall         = (state != ST_IDLE) || ((state == ST_IDLE) && issue_valid);

endmodule
